// File: rtl/rsf_pkg.sv
// Shared constants for the register status file: default widths and the
// "no producer" tag value.
package rsf_pkg;

  localparam int unsigned DEFAULT_DATA_W = 16;
  localparam int unsigned DEFAULT_NREG   = 8;
  localparam int unsigned DEFAULT_TAG_W  = 3;
  localparam int unsigned TAG_NONE       = 0;

endpackage

// File: rtl/rsf_read_port.sv
// One register-file read port: full address mux over the architectural view,
// with a same-cycle bypass of a matching common-data-bus broadcast.
module rsf_read_port
  import rsf_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W,
  parameter int unsigned NREG   = DEFAULT_NREG,
  parameter int unsigned TAG_W  = DEFAULT_TAG_W,
  parameter int unsigned AW     = $clog2(NREG)
) (
  input  logic [AW-1:0]                addr,
  input  logic [NREG-1:0][DATA_W-1:0]  reg_data,
  input  logic [NREG-1:0][TAG_W-1:0]   reg_tag,
  input  logic                         cdb_valid,
  input  logic [TAG_W-1:0]             cdb_tag,
  input  logic [DATA_W-1:0]            cdb_data,
  output logic [DATA_W-1:0]            data,
  output logic [TAG_W-1:0]             tag
);

  logic [DATA_W-1:0] sel_data;
  logic [TAG_W-1:0]  sel_tag;
  logic              hit;

  always_comb begin
    sel_data = '0;
    sel_tag  = TAG_W'(TAG_NONE);
    for (int unsigned i = 0; i < NREG; i++) begin
      if (addr == AW'(i)) begin
        sel_data = reg_data[i];
        sel_tag  = reg_tag[i];
      end
    end
    hit  = cdb_valid && (cdb_tag != TAG_W'(TAG_NONE)) && (addr != '0) && (sel_tag == cdb_tag);
    data = hit ? cdb_data : sel_data;
    tag  = hit ? TAG_W'(TAG_NONE) : sel_tag;
  end

endmodule

// File: rtl/reg_status_file.sv
// Register status file for a Tomasulo-style core: per-register data plus the
// tag of its pending producer, renamed on issue and resolved by CDB broadcast.
module reg_status_file
  import rsf_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W,
  parameter int unsigned NREG   = DEFAULT_NREG,
  parameter int unsigned TAG_W  = DEFAULT_TAG_W,
  localparam int unsigned AW    = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AW-1:0]     ra_addr,
  input  logic [AW-1:0]     rb_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  output logic [TAG_W-1:0]  ra_tag,
  output logic [TAG_W-1:0]  rb_tag,
  input  logic              issue_en,
  input  logic [AW-1:0]     issue_rd,
  input  logic [TAG_W-1:0]  issue_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic              flush,
  output logic [AW:0]       busy_cnt
);

  // Register 0 has no storage; it is a constant zero entry in the read view.
  logic [DATA_W-1:0] data_q [1:NREG-1];
  logic [TAG_W-1:0]  qi_q   [1:NREG-1];
  logic [DATA_W-1:0] data_d [1:NREG-1];
  logic [TAG_W-1:0]  qi_d   [1:NREG-1];
  logic [AW:0]       cnt_d;

  logic [NREG-1:0][DATA_W-1:0] view_data;
  logic [NREG-1:0][TAG_W-1:0]  view_tag;

  logic cdb_live;
  logic issue_ok;

  assign cdb_live = cdb_valid && (cdb_tag != TAG_W'(TAG_NONE));
  assign issue_ok = issue_en && (issue_rd != '0) && (issue_tag != TAG_W'(TAG_NONE));

  // CDB resolves first, then issue overrides the tag so a same-cycle
  // rename of a resolving register keeps the new producer.
  always_comb begin
    data_d = data_q;
    qi_d   = qi_q;
    cnt_d  = '0;
    for (int unsigned i = 1; i < NREG; i++) begin
      if (cdb_live && (qi_q[i] == cdb_tag)) begin
        data_d[i] = cdb_data;
        qi_d[i]   = TAG_W'(TAG_NONE);
      end
      if (flush) begin
        qi_d[i] = TAG_W'(TAG_NONE);
      end else if (issue_ok && (issue_rd == AW'(i))) begin
        qi_d[i] = issue_tag;
      end
      if (qi_d[i] != TAG_W'(TAG_NONE)) begin
        cnt_d = cnt_d + (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q   <= '{default: '0};
      qi_q     <= '{default: '0};
      busy_cnt <= '0;
    end else begin
      data_q   <= data_d;
      qi_q     <= qi_d;
      busy_cnt <= cnt_d;
    end
  end

  always_comb begin
    view_data = '0;
    view_tag  = '0;
    for (int unsigned i = 1; i < NREG; i++) begin
      view_data[i] = data_q[i];
      view_tag[i]  = qi_q[i];
    end
  end

  rsf_read_port #(
    .DATA_W (DATA_W),
    .NREG   (NREG),
    .TAG_W  (TAG_W),
    .AW     (AW)
  ) u_port_a (
    .addr      (ra_addr),
    .reg_data  (view_data),
    .reg_tag   (view_tag),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .data      (ra_data),
    .tag       (ra_tag)
  );

  rsf_read_port #(
    .DATA_W (DATA_W),
    .NREG   (NREG),
    .TAG_W  (TAG_W),
    .AW     (AW)
  ) u_port_b (
    .addr      (rb_addr),
    .reg_data  (view_data),
    .reg_tag   (view_tag),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .data      (rb_data),
    .tag       (rb_tag)
  );

endmodule

// File: tb/tb_reg_status_file.sv
// Self-checking bench for reg_status_file: directed vector table, reset
// corner sequences, then random traffic against a behavioural model.
module tb_reg_status_file;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  ra_addr, rb_addr;
  logic [15:0] ra_data, rb_data;
  logic [2:0]  ra_tag, rb_tag;
  logic        issue_en;
  logic [2:0]  issue_rd, issue_tag;
  logic        cdb_valid;
  logic [2:0]  cdb_tag;
  logic [15:0] cdb_data;
  logic        flush;
  logic [3:0]  busy_cnt;

  int errors = 0;
  int checks = 0;

  reg_status_file #(
    .DATA_W (16),
    .NREG   (8),
    .TAG_W  (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ra_addr   (ra_addr),
    .rb_addr   (rb_addr),
    .ra_data   (ra_data),
    .rb_data   (rb_data),
    .ra_tag    (ra_tag),
    .rb_tag    (rb_tag),
    .issue_en  (issue_en),
    .issue_rd  (issue_rd),
    .issue_tag (issue_tag),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .flush     (flush),
    .busy_cnt  (busy_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ie;
    logic [2:0]  rd;
    logic [2:0]  it;
    logic        cv;
    logic [2:0]  ct;
    logic [15:0] cd;
    logic        fl;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [15:0] e_rad;
    logic [2:0]  e_rat;
    logic [15:0] e_rbd;
    logic [2:0]  e_rbt;
    logic [3:0]  e_busy;
  } vec_t;

  vec_t tbl [26];

  // Behavioural model: plain arrays, register 0 never written.
  logic [15:0] m_data [8];
  logic [2:0]  m_qi   [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ie, input logic [2:0] rd, input logic [2:0] it,
                       input logic cv, input logic [2:0] ct, input logic [15:0] cd,
                       input logic fl, input logic [2:0] ra, input logic [2:0] rb);
    issue_en = ie; issue_rd = rd; issue_tag = it;
    cdb_valid = cv; cdb_tag = ct; cdb_data = cd;
    flush = fl; ra_addr = ra; rb_addr = rb;
  endtask

  function automatic int model_busy();
    int n = 0;
    for (int i = 1; i < 8; i++) if (m_qi[i] != 3'd0) n++;
    return n;
  endfunction

  initial begin
    tbl[0]  = '{1,3,5, 0,0,16'h0000,0, 3,0, 16'h0000,0, 16'h0000,0, 1};
    tbl[1]  = '{0,0,0, 0,0,16'h0000,0, 3,3, 16'h0000,5, 16'h0000,5, 1};
    tbl[2]  = '{0,0,0, 1,5,16'hBEEF,0, 3,0, 16'hBEEF,0, 16'h0000,0, 0};
    tbl[3]  = '{0,0,0, 0,0,16'h0000,0, 3,0, 16'hBEEF,0, 16'h0000,0, 0};
    tbl[4]  = '{1,2,4, 0,0,16'h0000,0, 2,6, 16'h0000,0, 16'h0000,0, 1};
    tbl[5]  = '{1,6,4, 0,0,16'h0000,0, 2,6, 16'h0000,4, 16'h0000,0, 2};
    tbl[6]  = '{0,0,0, 1,4,16'h0012,0, 2,6, 16'h0012,0, 16'h0012,0, 0};
    tbl[7]  = '{0,0,0, 0,0,16'h0000,0, 2,6, 16'h0012,0, 16'h0012,0, 0};
    tbl[8]  = '{1,1,2, 0,0,16'h0000,0, 1,3, 16'h0000,0, 16'hBEEF,0, 1};
    tbl[9]  = '{1,1,3, 0,0,16'h0000,0, 1,3, 16'h0000,2, 16'hBEEF,0, 1};
    tbl[10] = '{0,0,0, 1,2,16'h1111,0, 1,3, 16'h0000,3, 16'hBEEF,0, 1};
    tbl[11] = '{0,0,0, 0,0,16'h0000,0, 1,3, 16'h0000,3, 16'hBEEF,0, 1};
    tbl[12] = '{0,0,0, 1,3,16'h2222,0, 1,3, 16'h2222,0, 16'hBEEF,0, 0};
    tbl[13] = '{0,0,0, 0,0,16'h0000,0, 1,3, 16'h2222,0, 16'hBEEF,0, 0};
    tbl[14] = '{1,4,1, 0,0,16'h0000,0, 4,1, 16'h0000,0, 16'h2222,0, 1};
    tbl[15] = '{1,4,6, 1,1,16'h00AA,0, 4,4, 16'h00AA,0, 16'h00AA,0, 1};
    tbl[16] = '{0,0,0, 0,0,16'h0000,0, 4,4, 16'h00AA,6, 16'h00AA,6, 1};
    tbl[17] = '{1,2,7, 0,0,16'h0000,0, 2,4, 16'h0012,0, 16'h00AA,6, 2};
    tbl[18] = '{1,3,2, 0,0,16'h0000,0, 3,2, 16'hBEEF,0, 16'h0012,7, 3};
    tbl[19] = '{1,5,7, 0,0,16'h0000,1, 5,4, 16'h0000,0, 16'h00AA,6, 0};
    tbl[20] = '{0,0,0, 0,0,16'h0000,0, 5,4, 16'h0000,0, 16'h00AA,0, 0};
    tbl[21] = '{1,0,3, 1,0,16'hFFFF,0, 0,2, 16'h0000,0, 16'h0012,0, 0};
    tbl[22] = '{0,0,0, 0,0,16'h0000,0, 0,2, 16'h0000,0, 16'h0012,0, 0};
    tbl[23] = '{1,7,5, 0,0,16'h0000,0, 7,0, 16'h0000,0, 16'h0000,0, 1};
    tbl[24] = '{0,0,0, 1,5,16'h5A5A,1, 7,0, 16'h5A5A,0, 16'h0000,0, 0};
    tbl[25] = '{0,0,0, 0,0,16'h0000,0, 7,0, 16'h5A5A,0, 16'h0000,0, 0};

    // Reset state, with the clock running
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 16'h0, 0, 0, 0);
    #2;
    for (int a = 0; a < 8; a++) begin
      ra_addr = 3'(a); rb_addr = 3'(7 - a);
      #1;
      chk($sformatf("reset ra_data[%0d]", a), 32'(ra_data), 32'h0);
      chk($sformatf("reset ra_tag[%0d]", a), 32'(ra_tag), 32'h0);
      chk($sformatf("reset rb_data[%0d]", 7 - a), 32'(rb_data), 32'h0);
      chk($sformatf("reset rb_tag[%0d]", 7 - a), 32'(rb_tag), 32'h0);
    end
    chk("reset busy_cnt", 32'(busy_cnt), 32'h0);
    #5 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors: reads sampled before the edge, busy_cnt after it
    for (int v = 0; v < 26; v++) begin
      drive(tbl[v].ie, tbl[v].rd, tbl[v].it, tbl[v].cv, tbl[v].ct, tbl[v].cd,
            tbl[v].fl, tbl[v].ra, tbl[v].rb);
      #3;
      chk($sformatf("vec%0d ra_data", v), 32'(ra_data), 32'(tbl[v].e_rad));
      chk($sformatf("vec%0d ra_tag", v),  32'(ra_tag),  32'(tbl[v].e_rat));
      chk($sformatf("vec%0d rb_data", v), 32'(rb_data), 32'(tbl[v].e_rbd));
      chk($sformatf("vec%0d rb_tag", v),  32'(rb_tag),  32'(tbl[v].e_rbt));
      @(posedge clk); #1;
      chk($sformatf("vec%0d busy_cnt", v), 32'(busy_cnt), 32'(tbl[v].e_busy));
    end

    // Reset asserted mid-operation discards pending tags and held issues
    drive(1, 1, 4, 0, 0, 16'h0, 0, 1, 7);
    @(posedge clk); #1;
    chk("pre-reset busy_cnt", 32'(busy_cnt), 32'd1);
    chk("pre-reset ra_tag", 32'(ra_tag), 32'd4);
    drive(1, 3, 2, 0, 0, 16'h0, 0, 1, 7);
    rst_n = 1'b0;
    #1;
    chk("async reset busy_cnt", 32'(busy_cnt), 32'd0);
    chk("async reset ra_tag", 32'(ra_tag), 32'd0);
    chk("async reset rb_data", 32'(rb_data), 32'd0);
    @(posedge clk); #1;
    chk("held reset busy_cnt", 32'(busy_cnt), 32'd0);
    #2 rst_n = 1'b1;
    ra_addr = 3'd3;
    @(posedge clk); #1;
    chk("post-reset issue busy_cnt", 32'(busy_cnt), 32'd1);
    chk("post-reset issue ra_tag", 32'(ra_tag), 32'd2);
    drive(0, 0, 0, 0, 0, 16'h0, 1, 0, 0);
    @(posedge clk); #1;
    chk("cleanup flush busy_cnt", 32'(busy_cnt), 32'd0);

    // Random traffic against the model (all data zero after the reset above)
    for (int i = 0; i < 8; i++) begin
      m_data[i] = 16'h0;
      m_qi[i]   = 3'd0;
    end
    for (int n = 0; n < 400; n++) begin
      logic [15:0] nd [8];
      logic [2:0]  nq [8];
      logic [2:0]  ct;
      ct = ($urandom_range(0, 1) == 1) ? m_qi[$urandom_range(0, 7)] : 3'($urandom_range(0, 7));
      drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            ($urandom_range(0, 2) != 0), ct, 16'($urandom),
            ($urandom_range(0, 19) == 0), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      #3;
      begin
        logic [15:0] ead, ebd;
        logic [2:0]  eat, ebt;
        ead = m_data[ra_addr]; eat = m_qi[ra_addr];
        ebd = m_data[rb_addr]; ebt = m_qi[rb_addr];
        if (cdb_valid && cdb_tag != 0 && ra_addr != 0 && m_qi[ra_addr] == cdb_tag) begin
          ead = cdb_data; eat = 3'd0;
        end
        if (cdb_valid && cdb_tag != 0 && rb_addr != 0 && m_qi[rb_addr] == cdb_tag) begin
          ebd = cdb_data; ebt = 3'd0;
        end
        chk("rand ra_data", 32'(ra_data), 32'(ead));
        chk("rand ra_tag",  32'(ra_tag),  32'(eat));
        chk("rand rb_data", 32'(rb_data), 32'(ebd));
        chk("rand rb_tag",  32'(rb_tag),  32'(ebt));
      end
      nd = m_data; nq = m_qi;
      for (int r = 1; r < 8; r++) begin
        if (cdb_valid && cdb_tag != 0 && m_qi[r] == cdb_tag) begin
          nd[r] = cdb_data; nq[r] = 3'd0;
        end
      end
      if (flush) begin
        for (int r = 0; r < 8; r++) nq[r] = 3'd0;
      end else if (issue_en && issue_rd != 0 && issue_tag != 0) begin
        nq[issue_rd] = issue_tag;
      end
      m_data = nd; m_qi = nq;
      @(posedge clk); #1;
      chk("rand busy_cnt", 32'(busy_cnt), 32'(model_busy()));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_status_file.md
REG_STATUS_FILE -- requirements
Module: reg_status_file

Interface
REQ-001 Parameter DATA_W, default 16, register data width in bits.
REQ-002 Parameter NREG, default 8, number of architectural registers; address width AW = clog2(NREG).
REQ-003 Parameter TAG_W, default 3, reservation-station tag width; tag value 0 means "no producer, data valid".
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 ra_addr, rb_addr  input  AW each  read-port addresses.
REQ-007 ra_data, rb_data  output  DATA_W each  read-port data.
REQ-008 ra_tag, rb_tag  output  TAG_W each  pending producer tag; 0 means the data is valid.
REQ-009 issue_en  input  1  rename request for the destination register.
REQ-010 issue_rd  input  AW  destination register being renamed.
REQ-011 issue_tag  input  TAG_W  producing station tag.
REQ-012 cdb_valid  input  1  common-data-bus broadcast strobe.
REQ-013 cdb_tag  input  TAG_W  tag of the broadcasting station.
REQ-014 cdb_data  input  DATA_W  broadcast result.
REQ-015 flush  input  1  clear all pending tags.
REQ-016 busy_cnt  output  AW+1  count of registers with a nonzero tag, registered.

Function
REQ-017 State per register i: data[i] (DATA_W) and qi[i] (TAG_W).
REQ-018 Register 0 is hardwired: reads return data 0, tag 0; issue and CDB writes to it are ignored.
REQ-019 Reads are combinational from current state, with zero latency.
REQ-020 CDB bypass: if cdb_valid and qi[addr]==cdb_tag, with cdb_tag nonzero and addr nonzero, the port returns cdb_data with tag 0 in the same cycle.
REQ-021 Issue does not bypass: reads in the issue cycle return the pre-issue tag and data.
REQ-022 On cdb_valid with a nonzero cdb_tag, every register i!=0 with qi[i]==cdb_tag loads data[i]=cdb_data and clears qi[i] to 0 at the next edge; multiple matches all update.
REQ-023 cdb_valid with cdb_tag==0 has no effect.
REQ-024 On issue_en with issue_rd!=0 and issue_tag!=0, qi[issue_rd] loads issue_tag at the next edge; issue_tag==0 or issue_rd==0 is ignored.
REQ-025 Issue and a matching CDB to the same register in the same cycle: data[rd] takes cdb_data and qi[rd] takes issue_tag, so issue wins the tag.
REQ-026 Issue re-renaming a register that is already pending overwrites qi with the new tag; a later CDB carrying the old tag no longer updates that register.
REQ-027 flush clears all qi to 0 at the next edge, and data keeps its value except for CDB writes in the same cycle, which still land.
REQ-028 flush outranks issue in the same cycle: the issue is discarded.
REQ-029 busy_cnt equals the number of nonzero qi after each edge and is updated in the same edge as qi, computed from next-state values.

Reset
REQ-030 While rst_n is low: all data = 0, all qi = 0, busy_cnt = 0, independent of clk.
REQ-031 Reset asserted mid-operation discards pending tags and issues; the first edge after deassertion accepts issue and CDB normally.
REQ-032 During reset, read outputs reflect reset state: data 0, tag 0, except CDB bypass, which stays combinational.

Structure
REQ-033 Shared package rsf_pkg holds TAG_NONE (=0) and the default DATA_W, NREG and TAG_W constants.
REQ-034 One sub-module, rsf_read_port (address mux plus CDB bypass), is instantiated twice, once per read port.
REQ-035 No latches; every read-mux case is fully specified, including address 0.

Verification
REQ-036 Reset, then read all addresses -> data 0, tag 0, busy_cnt 0.
REQ-037 Issue rd=3 tag=5; next cycle read 3 -> tag 5, busy_cnt 1; CDB tag=5 data=16'hBEEF -> same-cycle ra_data BEEF with tag 0, next cycle stored, busy_cnt 0.
REQ-038 Issue rd=2 tag=4 and rd=6 tag=4 on successive cycles; CDB tag 4 data 16'h0012 -> both registers hold 0012 with tag 0, busy_cnt drops from 2 to 0.
REQ-039 Issue rd=1 tag=2, then issue rd=1 tag=3; CDB tag 2 data 16'h1111 -> reg 1 unchanged, tag 3; CDB tag 3 data 16'h2222 -> reg 1 = 2222.
REQ-040 Same cycle: issue rd=4 tag=6 and CDB with old tag 1 matching reg 4, data 16'h00AA -> data[4]=00AA, qi[4]=6.
REQ-041 Three regs pending, then flush with simultaneous issue rd=5 tag=7 -> all tags 0, busy_cnt 0, issue dropped; attempted writes to reg 0 always read back 0.
